// File: rtl/ifetch_queue_pkg.sv
// Shared CPU constants and types for the instruction-fetch front end.
//   CPU_RESET_PC : first fetch address after reset
//   INST_W       : instruction width in bits
//   PC_INC       : sequential PC step
//   fq_entry_t   : one queue entry, {instruction, instruction address + 4}
package ifetch_queue_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'd0;
    localparam int          INST_W       = 32;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam int          ENTRY_W      = INST_W + 32;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc4;
    } fq_entry_t;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Synchronous FIFO holding fetched instructions.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write one entry
//   pop        : remove the head entry
//   clear      : drop all entries; wins over push and pop
//   count      : number of valid entries (0..DEPTH)
//   head       : oldest entry, read straight from storage
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0) && !clear;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && !clear && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential instruction-memory reads under a
// credit limit, queues the returned words with their PC+4, and flushes on a
// redirect while discarding reads that were already in flight.
//   redirect, redirect_pc          : taken branch / jump from MEM and its target
//   imem_req, imem_addr, imem_ready: read request handshake
//   imem_rvalid, imem_rdata        : in-order read responses
//   out_valid, out_inst, out_pc4   : head entry presented to decode
//   out_ready                      : decode consumes the head (not load-use stalled)
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       out_pc4,
    input  logic              out_ready
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = 2;
    localparam int SW = $clog2(DEPTH+MAX_OUT+1);

    logic              run;
    logic [31:0]       fetch_pc;
    logic [31:0]       resp_pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     discard;
    logic [CW-1:0]     count;
    logic [SW-1:0]     credit_used;
    logic              accept;
    logic              push;
    logic              pop;
    fq_entry_t         push_e;
    fq_entry_t         head_e;

    // Every unanswered read owns a queue slot, so a response always fits.
    assign credit_used = SW'(count) + SW'(outstanding);
    assign imem_req    = run && !redirect
                       && (credit_used < SW'(DEPTH))
                       && (outstanding < OW'(MAX_OUT));
    assign imem_addr   = fetch_pc;
    assign accept      = imem_req && imem_ready;

    assign push   = imem_rvalid && !redirect && (discard == '0);
    assign pop    = out_valid && out_ready && !redirect;
    assign push_e = '{inst: imem_rdata, pc4: resp_pc + PC_INC};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   (push_e),
        .count (count),
        .head  (head_e)
    );

    assign out_valid = (count != '0);
    assign out_inst  = head_e.inst;
    assign out_pc4   = head_e.pc4;

    // outstanding counts every unanswered read, stale or not; discard is the
    // stale subset. On a redirect all reads still unanswered become stale,
    // which keeps discard <= outstanding <= MAX_OUT across chained redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            run <= 1'b1;
            if (redirect) begin
                fetch_pc    <= redirect_pc;
                resp_pc     <= redirect_pc;
                outstanding <= outstanding - OW'(imem_rvalid);
                discard     <= outstanding - OW'(imem_rvalid);
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_INC;
                if (push)   resp_pc  <= resp_pc + PC_INC;
                if (imem_rvalid && (discard != '0))
                    discard <= discard - OW'(1);
                outstanding <= outstanding + OW'(accept) - OW'(imem_rvalid);
            end
        end
    end

endmodule
